// File: rtl/sq_df_acc.sv
// Sum-of-squared-differences accumulator.
// Each accepted element is one unsigned squared difference from the upstream
// sq_df stage. Once the latched band count has been reached, the saturated
// sum is published for a single cycle on acc_valid. acc_out and overflow keep
// that value until the next completion, clear, or reset.
module sq_df_acc #(
    parameter int DATA_WIDTH   = 16,
    parameter int HS_BANDS_MAX = 128,
    parameter int ACC_WIDTH    = 40,
    localparam int BW          = $clog2(HS_BANDS_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [BW-1:0]           hs_bands,
    input  logic [2*DATA_WIDTH-1:0] data_in,
    input  logic                    data_in_valid,
    output logic [ACC_WIDTH-1:0]    acc_out,
    output logic                    acc_valid,
    output logic                    overflow,
    output logic                    busy
);

    localparam int AW1 = ACC_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] sum_next;
    logic                 sat;
    logic                 sat_next;
    logic [AW1-1:0]       add_full;
    logic [BW-1:0]        count;
    logic [BW-1:0]        count_inc;
    logic [BW-1:0]        bands_lat;
    logic [BW-1:0]        bands_eff;
    logic                 first_take;
    logic                 acc_take;
    logic                 done_first;
    logic                 done_acc;

    // Datapath decode: acceptance, band clamping, saturating add, completion.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        bands_eff = hs_bands;
        if (hs_bands > BW'(HS_BANDS_MAX)) begin
            bands_eff = BW'(HS_BANDS_MAX);
        end

        // A zero band count in IDLE means "no vector", so the element is dropped.
        first_take = (state == IDLE) && data_in_valid && !clear && (hs_bands != '0);
        acc_take   = (state == ACC)  && data_in_valid && !clear;
        done_first = first_take && (bands_eff == BW'(1));

        count_inc = count + BW'(1);
        done_acc  = acc_take && (count_inc == bands_lat);

        // The extra carry bit detects wrap; once saturated, the all-ones sum
        // plus any non-zero element carries again, so it stays at all-ones.
        add_full = {1'b0, sum} + AW1'(data_in);
        sum_next = add_full[ACC_WIDTH-1:0];
        if (add_full[ACC_WIDTH]) begin
            sum_next = '1;
        end
        // Sticky, so a vector that saturated reports it even if later adds of 0 carry nothing.
        sat_next = sat | add_full[ACC_WIDTH];
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; clear overrides any element on the same edge.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (first_take && !done_first) state_next = ACC;
                ACC:     if (done_acc)                  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: busy marks a partially accumulated vector.
    always_comb begin
        busy = (state == ACC);
    end

    // Accumulator, band counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            sat       <= 1'b0;
            count     <= '0;
            bands_lat <= '0;
            acc_out   <= '0;
            overflow  <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (clear) begin
                sum      <= '0;
                sat      <= 1'b0;
                count    <= '0;
                acc_out  <= '0;
                overflow <= 1'b0;
            end else if (first_take) begin
                bands_lat <= bands_eff;
                sum       <= ACC_WIDTH'(data_in);
                sat       <= 1'b0;
                count     <= BW'(1);
                if (done_first) begin
                    acc_out   <= ACC_WIDTH'(data_in);
                    overflow  <= 1'b0;
                    acc_valid <= 1'b1;
                end
            end else if (acc_take) begin
                sum   <= sum_next;
                sat   <= sat_next;
                count <= count_inc;
                if (done_acc) begin
                    acc_out   <= sum_next;
                    overflow  <= sat_next;
                    acc_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sq_df_acc.sv
// Self-checking bench for sq_df_acc: a default-width instance for the main
// behaviour and a narrow (4/8-bit) instance for saturation. Expected results
// are queued when the last element of a vector is driven and compared when
// acc_valid appears, including the cycle in which it must appear.
module tb_sq_df_acc;

    localparam int BW = $clog2(128 + 1);

    typedef struct {
        logic [39:0] acc;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t q_d[$];
    exp_t q_s[$];

    // Default-width instance
    logic          clear = 1'b0;
    logic [BW-1:0] hs_bands = '0;
    logic [31:0]   data_in = '0;
    logic          data_in_valid = 1'b0;
    logic [39:0]   acc_out;
    logic          acc_valid;
    logic          overflow;
    logic          busy;

    // Narrow instance
    logic          s_clear = 1'b0;
    logic [BW-1:0] s_bands = '0;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_acc_out;
    logic          s_acc_valid;
    logic          s_overflow;
    logic          s_busy;

    sq_df_acc dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .hs_bands(hs_bands),
        .data_in(data_in), .data_in_valid(data_in_valid),
        .acc_out(acc_out), .acc_valid(acc_valid), .overflow(overflow), .busy(busy)
    );

    sq_df_acc #(.DATA_WIDTH(4), .HS_BANDS_MAX(128), .ACC_WIDTH(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .hs_bands(s_bands),
        .data_in(s_data), .data_in_valid(s_valid),
        .acc_out(s_acc_out), .acc_valid(s_acc_valid), .overflow(s_overflow), .busy(s_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard for the default instance
    always @(negedge clk) begin
        if (acc_valid === 1'b1) begin
            if (q_d.size() == 0) begin
                check("d_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_d.pop_front();
                check("d_acc_out", acc_out, e.acc);
                check("d_overflow", overflow, e.ovf);
                check("d_latency", cyc, e.cyc);
            end
        end
    end

    // Scoreboard for the narrow instance
    always @(negedge clk) begin
        if (s_acc_valid === 1'b1) begin
            if (q_s.size() == 0) begin
                check("s_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_s.pop_front();
                check("s_acc_out", s_acc_out, e.acc[7:0]);
                check("s_overflow", s_overflow, e.ovf);
                check("s_latency", cyc, e.cyc);
            end
        end
    end

    task automatic send(input logic [31:0] d, input int b, input bit last,
                        input logic [39:0] exp_acc, input bit exp_ovf);
        exp_t e;
        @(negedge clk);
        data_in       = d;
        hs_bands      = BW'(b);
        data_in_valid = 1'b1;
        clear         = 1'b0;
        if (last) begin
            e.acc = exp_acc; e.ovf = exp_ovf; e.cyc = cyc + 1;
            q_d.push_back(e);
        end
    endtask

    task automatic send_s(input logic [7:0] d, input int b, input bit last,
                          input logic [39:0] exp_acc, input bit exp_ovf);
        exp_t e;
        @(negedge clk);
        s_data  = d;
        s_bands = BW'(b);
        s_valid = 1'b1;
        if (last) begin
            e.acc = exp_acc; e.ovf = exp_ovf; e.cyc = cyc + 1;
            q_s.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_in_valid = 1'b0;
            s_valid       = 1'b0;
            clear         = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_acc_out", acc_out, 0);
        check("rst_acc_valid", acc_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 4,9,1,16 over 4 bands -> 30
        send(4, 4, 0, 0, 0);
        check("busy_after_first", busy, 0);   // not yet sampled
        send(9, 4, 0, 0, 0);
        check("busy_in_acc", busy, 1);
        send(1, 4, 0, 0, 0);
        send(16, 4, 1, 30, 0);
        idle(3);

        // 2,0, gap of 2, then 5 over 3 bands -> 7
        send(2, 3, 0, 0, 0);
        send(0, 3, 0, 0, 0);
        idle(1);
        check("busy_gap1", busy, 1);
        idle(1);
        check("busy_gap2", busy, 1);
        send(5, 3, 1, 7, 0);
        idle(3);

        // Back-to-back 2-band vectors, then single-band vectors
        send(1, 2, 0, 0, 0);
        send(2, 2, 1, 3, 0);
        send(3, 2, 0, 0, 0);
        send(4, 2, 1, 7, 0);
        send(25, 1, 1, 25, 0);
        send(6, 1, 1, 6, 0);
        idle(3);

        // Zero band count in IDLE is ignored
        send(7, 0, 0, 0, 0);
        idle(1);
        check("zero_bands_busy", busy, 0);
        check("zero_bands_acc_out", acc_out, 6);

        // Clear mid-vector (with a valid element on the same edge), then 1,1,1,1
        send(10, 4, 0, 0, 0);
        send(10, 4, 0, 0, 0);
        @(negedge clk);
        clear = 1'b1; data_in_valid = 1'b1; data_in = 99;
        idle(1);
        check("clear_acc_out", acc_out, 0);
        check("clear_busy", busy, 0);
        check("clear_overflow", overflow, 0);
        send(1, 4, 0, 0, 0);
        send(1, 4, 0, 0, 0);
        send(1, 4, 0, 0, 0);
        send(1, 4, 1, 4, 0);
        idle(3);

        // hs_bands above the maximum clamps to 128; later changes are ignored
        send(1, 200, 0, 0, 0);
        for (int i = 1; i < 127; i++) send(1, 2, 0, 0, 0);
        check("clamp_busy", busy, 1);
        send(1, 2, 1, 128, 0);
        idle(3);

        // Asynchronous reset mid-vector
        send(1, 4, 0, 0, 0);
        send(2, 4, 0, 0, 0);
        @(negedge clk);
        data_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_acc_out", acc_out, 0);
        check("arst_busy", busy, 0);
        check("arst_overflow", overflow, 0);
        check("arst_acc_valid", acc_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1, 4, 0, 0, 0);
        send(2, 4, 0, 0, 0);
        send(3, 4, 0, 0, 0);
        send(4, 4, 1, 10, 0);
        idle(3);

        // Narrow instance: saturation, stickiness, recovery
        send_s(200, 2, 0, 0, 0);
        send_s(100, 2, 1, 255, 1);
        send_s(1, 2, 0, 0, 0);
        send_s(1, 2, 1, 2, 0);
        send_s(250, 3, 0, 0, 0);
        send_s(10, 3, 0, 0, 0);
        send_s(0, 3, 1, 255, 1);
        idle(2);
        check("s_hold_acc_out", s_acc_out, 255);
        check("s_hold_overflow", s_overflow, 1);
        idle(3);

        check("d_drained", q_d.size(), 0);
        check("s_drained", q_s.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
